// File: rtl/mcycle_pkg.sv
// rtl/mcycle_pkg.sv - shared op/state encodings and default width for the multi-cycle mul/div unit
package mcycle_pkg;

    localparam int MCYCLE_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_SMUL = 2'b00,
        OP_UMUL = 2'b01,
        OP_SDIV = 2'b10,
        OP_UDIV = 2'b11
    } mcycle_op_e;

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_COMPUTING = 1'b1
    } mcycle_state_e;

endpackage

// File: rtl/mcycle_divstep.sv
// rtl/mcycle_divstep.sv - one restoring-division step: shift in a dividend bit, subtract divisor if it fits
module mcycle_divstep
    import mcycle_pkg::*;
#(
    parameter int WIDTH = MCYCLE_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_div,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0] w_diff;

    // A set borrow bit means the shifted remainder was smaller than the divisor.
    assign w_diff = {i_rem, i_bit} - {1'b0, i_div};
    assign o_q    = ~w_diff[WIDTH];
    assign o_rem  = o_q ? w_diff[WIDTH-1:0] : {i_rem[WIDTH-2:0], i_bit};

endmodule

// File: rtl/mcycle.sv
// rtl/mcycle.sv - iterative shift-add multiplier / restoring divider; divide path built only with MCYCLE_DIV_EN
module mcycle
    import mcycle_pkg::*;
#(
    parameter int WIDTH = MCYCLE_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);

    localparam int CW = $clog2(WIDTH);

    mcycle_state_e      r_state;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg_lo;
    logic [WIDTH-1:0]   r_result1;
    logic [WIDTH-1:0]   r_result2;

    logic               w_signed;
    logic               w_s1;
    logic               w_s2;
    logic               w_last;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_prod;

    assign w_signed = (MCycleOp == OP_SMUL) || (MCycleOp == OP_SDIV);
    assign w_s1     = w_signed & Operand1[WIDTH-1];
    assign w_s2     = w_signed & Operand2[WIDTH-1];
    assign w_mag1   = w_s1 ? -Operand1 : Operand1;
    assign w_mag2   = w_s2 ? -Operand2 : Operand2;
    assign w_last   = (r_count == CW'(WIDTH - 1));

    // Accumulator is {partial product high, remaining multiplier bits}; add then shift right.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};
    assign w_prod     = r_neg_lo ? -w_mul_next : w_mul_next;

    assign Busy    = (r_state == S_COMPUTING) || ((r_state == S_IDLE) && Start);
    assign Result1 = r_result1;
    assign Result2 = r_result2;

`ifdef MCYCLE_DIV_EN
    logic               r_is_div;
    logic               r_neg_hi;
    logic [WIDTH-1:0]   w_rem;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quo_out;
    logic [WIDTH-1:0]   w_rem_out;

    mcycle_divstep #(.WIDTH(WIDTH)) u_divstep (
        .i_rem (r_acc[2*WIDTH-1:WIDTH]),
        .i_div (r_mcand),
        .i_bit (r_acc[WIDTH-1]),
        .o_rem (w_rem),
        .o_q   (w_qbit)
    );

    // Accumulator is {partial remainder, dividend bits not yet consumed, quotient bits so far}.
    assign w_div_next = {w_rem, r_acc[WIDTH-2:0], w_qbit};
    assign w_quo_out  = r_neg_lo ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0];
    assign w_rem_out  = r_neg_hi ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_neg_lo  <= 1'b0;
            r_result1 <= '0;
            r_result2 <= '0;
`ifdef MCYCLE_DIV_EN
            r_is_div  <= 1'b0;
            r_neg_hi  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
`ifdef MCYCLE_DIV_EN
                        r_is_div <= MCycleOp[1];
                        r_neg_hi <= MCycleOp[1] & w_s1;
                        if (MCycleOp[1]) begin
                            r_acc    <= {{WIDTH{1'b0}}, w_mag1};
                            r_mcand  <= w_mag2;
                            // Divide by zero yields an all-ones quotient, so it must not be negated.
                            r_neg_lo <= (w_s1 ^ w_s2) & (Operand2 != '0);
                        end else begin
                            r_acc    <= {{WIDTH{1'b0}}, w_mag2};
                            r_mcand  <= w_mag1;
                            r_neg_lo <= w_s1 ^ w_s2;
                        end
                        r_count <= '0;
                        r_state <= S_COMPUTING;
`else
                        if (MCycleOp[1]) begin
                            r_result1 <= '0;
                            r_result2 <= '0;
                        end else begin
                            r_acc    <= {{WIDTH{1'b0}}, w_mag2};
                            r_mcand  <= w_mag1;
                            r_neg_lo <= w_s1 ^ w_s2;
                            r_count  <= '0;
                            r_state  <= S_COMPUTING;
                        end
`endif
                    end
                end
                S_COMPUTING: begin
                    r_count <= r_count + 1'b1;
`ifdef MCYCLE_DIV_EN
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    if (w_last) begin
                        r_result1 <= r_is_div ? w_quo_out : w_prod[WIDTH-1:0];
                        r_result2 <= r_is_div ? w_rem_out : w_prod[2*WIDTH-1:WIDTH];
                        r_state   <= S_IDLE;
                    end
`else
                    r_acc <= w_mul_next;
                    if (w_last) begin
                        r_result1 <= w_prod[WIDTH-1:0];
                        r_result2 <= w_prod[2*WIDTH-1:WIDTH];
                        r_state   <= S_IDLE;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle.sv
// tb/tb_mcycle.sv - directed self-checking bench for mcycle; divide vectors depend on MCYCLE_DIV_EN
module tb_mcycle;
    import mcycle_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] res1;
    logic [31:0] res2;
    logic        busy;

    int n_tests;
    int n_fail;
    logic [31:0] last1;
    logic [31:0] last2;

    mcycle dut (
        .CLK      (clk),
        .RESET    (rst),
        .Start    (start),
        .MCycleOp (op),
        .Operand1 (opa),
        .Operand2 (opb),
        .Result1  (res1),
        .Result2  (res2),
        .Busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at a negedge; the current cycle becomes cycle 0. Returns at the negedge of cycle lat.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e1, input logic [31:0] e2, input int lat, input int inj);
        int busy_bad;
        busy_bad = 0;
        start = 1'b1; op = o; opa = a; opb = b;
        #1 check({tag, "_busy_c0"}, 64'(busy), 64'd1);
        for (int c = 1; c < lat; c++) begin
            next_cycle();
            start = (c == inj);
            op    = (c == inj) ? OP_UMUL : 2'($urandom);
            opa   = (c == inj) ? 32'hFFFF_FFFF : $urandom;
            opb   = (c == inj) ? 32'hFFFF_FFFF : $urandom;
            #1;
            if (!busy) busy_bad++;
            if (c == lat - 1) begin
                check({tag, "_hold_r1"}, 64'(res1), 64'(last1));
                check({tag, "_hold_r2"}, 64'(res2), 64'(last2));
            end
        end
        next_cycle();
        start = 1'b0;
        #1;
        check({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check({tag, "_r1"}, 64'(res1), 64'(e1));
        check({tag, "_r2"}, 64'(res2), 64'(e2));
        last1 = e1;
        last2 = e2;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; start = 1'b0; op = OP_UMUL; opa = '0; opb = '0;
        last1 = '0; last2 = '0;
        repeat (3) next_cycle();
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_r1", 64'(res1), 64'd0);
        check("reset_r2", 64'(res2), 64'd0);
        rst = 1'b0;
        next_cycle();

        run_op("umul_max", OP_UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 33, 0);
        run_op("smul_neg", OP_SMUL, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 33, 0);
        run_op("smul_b2b", OP_SMUL, 32'd2, 32'd3, 32'd6, 32'd0, 33, 0);
        run_op("smul_nn", OP_SMUL, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd6, 32'd0, 33, 0);

`ifdef MCYCLE_DIV_EN
        run_op("sdiv_trunc", OP_SDIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
        run_op("sdiv_ovf", OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 33, 0);
        run_op("udiv_zero", OP_UDIV, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0064, 33, 0);
        run_op("sdiv_zero", OP_SDIV, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 33, 0);
        run_op("udiv_100_7", OP_UDIV, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0);
        run_op("sdiv_pos_neg", OP_SDIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 0);
`else
        run_op("udiv_off", OP_UDIV, 32'h0000_0064, 32'h0000_0000, 32'd0, 32'd0, 1, 0);
        run_op("smul_after", OP_SMUL, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 33, 0);
        run_op("sdiv_off", OP_SDIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1, 0);
`endif

        run_op("start_busy", OP_UMUL, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 32'd0, 33, 5);

        // Abort a multiply with RESET asserted during cycle 10.
        start = 1'b1; op = OP_UMUL; opa = 32'd5; opb = 32'd5;
        next_cycle();
        start = 1'b0;
        for (int c = 2; c <= 10; c++) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_r1", 64'(res1), 64'd0);
        check("abort_r2", 64'(res2), 64'd0);
        repeat (30) next_cycle();
        #1;
        check("abort_nores", 64'({res2, res1}), 64'd0);
        last1 = '0; last2 = '0;

        // RESET and Start together: Busy follows Start combinationally, but no op begins.
        rst = 1'b1; start = 1'b1; op = OP_UMUL; opa = 32'd3; opb = 32'd3;
        #1 check("rst_start_busy", 64'(busy), 64'd1);
        next_cycle();
        rst = 1'b0; start = 1'b0;
        #1 check("rst_start_idle", 64'(busy), 64'd0);
        next_cycle();

        run_op("umul_recover", OP_UMUL, 32'd7, 32'd6, 32'd42, 32'd0, 33, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
